// File: rtl/cpu_harness.sv
// ---------------------------------------------------------------------------
// cpu_harness
//
// Run controller for the FRANK6000 CPU. It streams a program into the CPU
// instruction memory through a valid/ready port while holding the CPU in
// reset. It then releases the CPU and issues a periodic control-enable
// strobe. A run ends on a rising edge of the CPU loop flag or when the step
// count reaches the programmed timeout. At that point the working register
// value is captured.
//
// Optional feature:
//   CPU_HARNESS_CHECKSUM_EN - when defined, o_checksum holds the XOR of every
//   word accepted during the current load. When undefined, o_checksum is
//   tied to zero.
//
// Parameters:
//   DIV_W   control-enable divider width (strobe period is 2^DIV_W clocks)
//   ADDR_W  instruction address width
//   DATA_W  instruction word width
//   WREG_W  CPU working-register width
//   STEP_W  step counter / timeout width
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_start             begin a load (honoured in IDLE and DONE only)
//   i_load_valid/data/last, o_load_ready   program load stream
//   o_instr_addr/o_instr/o_instr_we        instruction memory write port
//   o_cpu_rst, o_ON, o_control_en          CPU control
//   i_WREG, i_loopf                        CPU status
//   i_timeout                              step limit (0 = no limit)
//   o_done, o_timeout, o_result, o_steps   run results
//   o_checksum                             XOR of loaded words
// ---------------------------------------------------------------------------
module cpu_harness #(
    parameter int DIV_W  = 2,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int WREG_W = 8,
    parameter int STEP_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_load_valid,
    input  logic [DATA_W-1:0] i_load_data,
    input  logic              i_load_last,
    output logic              o_load_ready,
    output logic [ADDR_W-1:0] o_instr_addr,
    output logic [DATA_W-1:0] o_instr,
    output logic              o_instr_we,
    output logic              o_cpu_rst,
    output logic              o_ON,
    output logic              o_control_en,
    input  logic [WREG_W-1:0] i_WREG,
    input  logic              i_loopf,
    input  logic [STEP_W-1:0] i_timeout,
    output logic              o_done,
    output logic              o_timeout,
    output logic [WREG_W-1:0] o_result,
    output logic [STEP_W-1:0] o_steps,
    output logic [DATA_W-1:0] o_checksum
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CLR,
        RUN,
        DONE
    } state_t;

    // A zero-width divider is not legal. With DIV_W=0 a one-bit counter is
    // still kept, but the strobe ignores it and fires on every RUN cycle.
    localparam int DIV_BITS = (DIV_W > 0) ? DIV_W : 1;

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam logic [STEP_W-1:0] STEP_MAX = '1;

    state_t              state;
    state_t              next_state;
    logic [ADDR_W-1:0]   addr;
    logic [DIV_BITS-1:0] div;
    logic                loopf_prev;

    logic handshake;
    logic last_word;
    logic start_load;
    logic strobe;
    logic loop_edge;
    logic timeout_hit;

    // Ready is high for the whole of LOAD, so a handshake is simply valid
    // while in LOAD. The final word is either flagged by the source or is
    // the one that lands on the top address. The address never wraps.
    assign handshake   = (state == LOAD) && i_load_valid;
    assign last_word   = i_load_last || (addr == ADDR_MAX);
    assign start_load  = ((state == IDLE) || (state == DONE)) && i_start;
    assign strobe      = (state == RUN) && ((DIV_W == 0) || (div == '0));
    assign loop_edge   = (state == RUN) && i_loopf && !loopf_prev;
    assign timeout_hit = (state == RUN) && (i_timeout != '0) && (o_steps == i_timeout);

    // State register. Reset returns to IDLE from any state, mid-load or
    // mid-run included.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. A loop-flag edge and a timeout both end the run.
    // The datapath below gives the loop flag priority when both occur.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (i_start) begin
                    next_state = LOAD;
                end
            end
            LOAD: begin
                if (handshake && last_word) begin
                    next_state = CLR;
                end
            end
            CLR: begin
                next_state = RUN;
            end
            RUN: begin
                if (loop_edge || timeout_hit) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (i_start) begin
                    next_state = LOAD;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Output decode from the current state. The CPU is held in reset
    // everywhere except RUN and DONE. In DONE the CPU stays out of reset
    // so its final state can still be inspected.
    always_comb begin
        o_load_ready = 1'b0;
        o_cpu_rst    = 1'b1;
        o_ON         = 1'b0;
        o_control_en = 1'b0;
        o_done       = 1'b0;
        case (state)
            LOAD: begin
                o_load_ready = 1'b1;
            end
            RUN: begin
                o_cpu_rst    = 1'b0;
                o_ON         = 1'b1;
                o_control_en = strobe;
            end
            DONE: begin
                o_cpu_rst = 1'b0;
                o_done    = 1'b1;
            end
            default: begin
                o_cpu_rst = 1'b1;
            end
        endcase
    end

    // Load datapath and run bookkeeping.
    //   - Each accepted word becomes a one-cycle write strobe.
    //   - The address and data stay on the bus after the write.
    //   - CLR wipes the previous run's results and the divider.
    //     This makes the first RUN cycle a strobe.
    //   - Results are captured on the cycle that decides the run is over.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            addr         <= '0;
            div          <= '0;
            loopf_prev   <= 1'b0;
            o_instr_we   <= 1'b0;
            o_instr_addr <= '0;
            o_instr      <= '0;
            o_steps      <= '0;
            o_timeout    <= 1'b0;
            o_result     <= '0;
        end else begin
            o_instr_we <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (i_start) begin
                        addr <= '0;
                    end
                end
                LOAD: begin
                    if (handshake) begin
                        o_instr_we   <= 1'b1;
                        o_instr_addr <= addr;
                        o_instr      <= i_load_data;
                        if (addr != ADDR_MAX) begin
                            addr <= addr + ADDR_W'(1);
                        end
                    end
                end
                CLR: begin
                    div        <= '0;
                    loopf_prev <= 1'b0;
                    o_steps    <= '0;
                    o_timeout  <= 1'b0;
                    o_result   <= '0;
                end
                RUN: begin
                    div        <= div + DIV_BITS'(1);
                    loopf_prev <= i_loopf;
                    if (strobe && (o_steps != STEP_MAX)) begin
                        o_steps <= o_steps + STEP_W'(1);
                    end
                    if (loop_edge) begin
                        o_result  <= i_WREG;
                        o_timeout <= 1'b0;
                    end else if (timeout_hit) begin
                        o_result  <= i_WREG;
                        o_timeout <= 1'b1;
                    end
                end
                default: begin
                    addr <= addr;
                end
            endcase
        end
    end

`ifdef CPU_HARNESS_CHECKSUM_EN
    // Running XOR of the program being loaded. It restarts with each new
    // load and is held otherwise, so it describes the program last loaded.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_checksum <= '0;
        end else if (start_load) begin
            o_checksum <= '0;
        end else if (handshake) begin
            o_checksum <= o_checksum ^ i_load_data;
        end
    end
`else
    assign o_checksum = '0;
`endif

endmodule
